uart_core_p: RTL and testbench
==============================

// Module: uart_core_p
// PURPOSE
//  Parametrised full-duplex UART: next generation of the fixed 8N1 uart, with generic bit timing, data width and stop bits.
//  Adds an RX FIFO, RX frame/overflow error reporting and optional parity.
//  Sits between the system bus (sys_clk_i domain) and the board serial pins.
// PARAMETERS
//  CLK_DIV        434  sys_clk_i cycles per bit (50 MHz / 115200); >= 4
//  DATA_BITS      8    data bits per frame, 5..9
//  STOP_BITS      1    stop bits, 1 or 2
//  RX_FIFO_DEPTH  4    RX FIFO entries, power of 2, >= 2
//  PARITY_ODD     0    0 even, 1 odd; used only with UART_PARITY_EN
// PORTS
//  sys_clk_i     in   1          system clock, single clock domain
//  sys_rst_i     in   1          synchronous, active-high reset
//  uart_wr_i     in   1          TX write strobe
//  uart_dat_i    in   DATA_BITS  TX data
//  uart_busy     out  1          TX frame in progress
//  uart_tx       out  1          serial out, idle high
//  uart_rx       in   1          serial in, asynchronous
//  uart_rd_i     in   1          RX FIFO pop
//  uart_dat_o    out  DATA_BITS  RX FIFO head, first-word-fall-through
//  uart_rx_busy  out  1          RX frame in progress
//  uart_rx_empty out  1          RX FIFO empty
//  uart_rx_full  out  1          RX FIFO full
//  uart_rx_ovf   out  1          sticky: byte lost to full FIFO
//  uart_frm_err  out  1          1-cycle pulse: stop bit sampled low
//  uart_par_err  out  1          1-cycle pulse: parity mismatch
// BEHAVIOUR
//  Reset: uart_tx=1, uart_busy=0, uart_rx_busy=0, uart_rx_empty=1, uart_rx_full=0, uart_rx_ovf=0, err pulses=0, uart_dat_o=0.
//   FIFO pointers cleared; a frame in progress on either side is aborted; uart_tx returns to 1 on the reset edge.
//  TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE:
//   - uart_wr_i & !uart_busy latches uart_dat_i; uart_busy=1 and uart_tx=0 from the next cycle.
//   - Each bit lasts exactly CLK_DIV cycles; data goes out LSB first; STOP drives 1 for STOP_BITS*CLK_DIV cycles.
//   - uart_busy falls the cycle after the last stop bit ends; back-to-back writes are allowed then.
//   - uart_wr_i while busy is ignored, with no effect on the current frame.
//  RX synchroniser: 2-flop on uart_rx; all detection uses the synchronised signal.
//  RX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE:
//   - A 1->0 edge in IDLE enters START and sets uart_rx_busy.
//   - Sample at CLK_DIV/2 into START: if 1, false start, return to IDLE and push nothing.
//   - Each later bit is sampled at its centre, CLK_DIV cycles apart; data is assembled LSB first.
//   - At the first stop-bit sample: 0 -> uart_frm_err pulse, byte discarded.
//     Otherwise the byte is pushed on the next cycle. uart_rx_busy falls at that sample and IDLE is re-armed.
//   - The second stop bit, if configured, is not checked.
//  RX FIFO:
//   - uart_rx_empty deasserts the cycle after the push; uart_dat_o = oldest entry whenever !uart_rx_empty.
//   - uart_rd_i & !empty pops; the next entry is visible the following cycle. uart_rd_i on empty is ignored.
//   - Push while full with no pop: byte dropped, uart_rx_ovf set, held until reset.
//   - Push and pop in the same cycle while full: both occur, no overflow.
//   - Pointers wrap modulo RX_FIFO_DEPTH; occupancy counter is log2(DEPTH)+1 bits.
//  Bit counters are sized ceil(log2(CLK_DIV)); a counter reloads, never free-runs, on each state change.
// CONFIGURATION
//  UART_PARITY_EN defined:
//   - One parity bit follows the data on TX (even if PARITY_ODD=0, else odd).
//   - RX checks it; on mismatch, uart_par_err pulses for 1 cycle and the byte is discarded (a framing error takes precedence).
//  UART_PARITY_EN undefined: no parity bit in either direction; uart_par_err is tied 0 and the port is kept.
// TESTING (CLK_DIV=434, defaults, 20 ns clock)
//  1. Reset 10 cycles, write 0x1B -> uart_tx is 0 for 434 cycles, then bits 1,1,0,1,1,0,0,0 at 434 each, then 1;
//     uart_busy high for exactly 4340 cycles.
//  2. Write 0x1B, then write 0x1E 100 cycles later -> only 0x1B sent; write 0x1E after busy falls -> 0x1E sent.
//  3. Drive an RX frame of 0x75 at 434 cycles/bit -> empty falls after the stop-bit centre, uart_dat_o=0x75;
//     pulse uart_rd_i -> empty=1.
//  4. Five RX frames 0x01..0x05 with no reads -> full=1 after the 4th, ovf=1 after the 5th; reads return 0x01..0x04.
//  5. Frame 0x55 with stop bit 0 -> uart_frm_err pulse, FIFO empty.
//     A 100-cycle low glitch -> no push, no error.
//  6. With UART_PARITY_EN, PARITY_ODD=0: TX 0x07 -> parity bit 1.
//     RX 0x07 with parity 0 -> uart_par_err pulse, no push.

Source files
------------

// File: rtl/uart_core_p.sv
// Parametrised full-duplex UART with RX FIFO, frame/overflow error reporting.
// Optional parity bit in both directions when UART_PARITY_EN is defined.
module uart_core_p #(
  parameter int unsigned CLK_DIV       = 434,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD    = 0
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic                 uart_wr_i,
  input  logic [DATA_BITS-1:0] uart_dat_i,
  output logic                 uart_busy,
  output logic                 uart_tx,
  input  logic                 uart_rx,
  input  logic                 uart_rd_i,
  output logic [DATA_BITS-1:0] uart_dat_o,
  output logic                 uart_rx_busy,
  output logic                 uart_rx_empty,
  output logic                 uart_rx_full,
  output logic                 uart_rx_ovf,
  output logic                 uart_frm_err,
  output logic                 uart_par_err
);

`ifdef UART_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam int unsigned PtrW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CntW-1:0] CntFull = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
  localparam logic            ParOdd  = (PARITY_ODD != 0);
  localparam logic            StopLast = (STOP_BITS == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------- TX ----------------
  state_e                tx_state_q;
  logic [CntW-1:0]       tx_cnt_q;
  logic [BitW-1:0]       tx_bit_q;
  logic                  tx_stop_q;
  logic [DATA_BITS-1:0]  tx_shift_q;
  logic                  tx_par_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      uart_tx    <= 1'b1;
      uart_busy  <= 1'b0;
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          if (uart_wr_i) begin
            tx_shift_q <= uart_dat_i;
            tx_par_q   <= (^uart_dat_i) ^ ParOdd;
            tx_cnt_q   <= CntFull;
            uart_tx    <= 1'b0;
            uart_busy  <= 1'b1;
            tx_state_q <= StStart;
          end
        end
        StStart: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q   <= CntFull;
            tx_bit_q   <= '0;
            uart_tx    <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_state_q <= StData;
          end else begin
            tx_cnt_q <= tx_cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= CntFull;
            if (tx_bit_q == BitLast) begin
              if (ParEn) begin
                uart_tx    <= tx_par_q;
                tx_state_q <= StParity;
              end else begin
                uart_tx    <= 1'b1;
                tx_stop_q  <= 1'b0;
                tx_state_q <= StStop;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + BitW'(1);
              uart_tx    <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CntW'(1);
          end
        end
        StParity: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q   <= CntFull;
            uart_tx    <= 1'b1;
            tx_stop_q  <= 1'b0;
            tx_state_q <= StStop;
          end else begin
            tx_cnt_q <= tx_cnt_q - CntW'(1);
          end
        end
        StStop: begin
          if (tx_cnt_q == '0) begin
            if (tx_stop_q == StopLast) begin
              uart_busy  <= 1'b0;
              tx_state_q <= StIdle;
            end else begin
              tx_stop_q <= 1'b1;
              tx_cnt_q  <= CntFull;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CntW'(1);
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  state_e               rx_state_q;
  logic [CntW-1:0]      rx_cnt_q;
  logic [BitW-1:0]      rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_q;
  logic                 par_err_q;
  logic                 push_q;
  logic [DATA_BITS-1:0] push_dat_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_state_q   <= StIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= 1'b0;
      par_err_q    <= 1'b0;
      push_q       <= 1'b0;
      push_dat_q   <= '0;
      uart_rx_busy <= 1'b0;
      uart_frm_err <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      uart_frm_err <= 1'b0;
      par_err_q    <= 1'b0;
      unique case (rx_state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_cnt_q     <= CntHalf;
            uart_rx_busy <= 1'b1;
            rx_state_q   <= StStart;
          end
        end
        StStart: begin
          if (rx_cnt_q == '0) begin
            if (rx_s2_q) begin
              uart_rx_busy <= 1'b0;
              rx_state_q   <= StIdle;
            end else begin
              rx_cnt_q   <= CntFull;
              rx_bit_q   <= '0;
              rx_state_q <= StData;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (rx_cnt_q == '0) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            rx_cnt_q   <= CntFull;
            if (rx_bit_q == BitLast) begin
              rx_state_q <= ParEn ? StParity : StStop;
            end else begin
              rx_bit_q <= rx_bit_q + BitW'(1);
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CntW'(1);
          end
        end
        StParity: begin
          if (rx_cnt_q == '0) begin
            rx_par_q   <= rx_s2_q;
            rx_cnt_q   <= CntFull;
            rx_state_q <= StStop;
          end else begin
            rx_cnt_q <= rx_cnt_q - CntW'(1);
          end
        end
        StStop: begin
          // Only the first stop bit is checked; IDLE re-arms at its centre.
          if (rx_cnt_q == '0) begin
            uart_rx_busy <= 1'b0;
            rx_state_q   <= StIdle;
            if (!rx_s2_q) begin
              uart_frm_err <= 1'b1;
            end else if (ParEn && (rx_par_q != ((^rx_shift_q) ^ ParOdd))) begin
              par_err_q <= 1'b1;
            end else begin
              push_q     <= 1'b1;
              push_dat_q <= rx_shift_q;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CntW'(1);
          end
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  assign uart_par_err = par_err_q;

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 do_push, do_pop;

  assign uart_rx_empty = (count_q == '0);
  assign uart_rx_full  = (count_q == (PtrW + 1)'(RX_FIFO_DEPTH));
  assign do_pop        = uart_rd_i && !uart_rx_empty;
  assign do_push       = push_q && (!uart_rx_full || do_pop);
  assign uart_dat_o    = uart_rx_empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge sys_clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      uart_rx_ovf <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_q && uart_rx_full && !do_pop) uart_rx_ovf <= 1'b1;
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

endmodule

// File: tb/tb_uart_core_p.sv
// Self-checking bench for uart_core_p: directed and random frames against a
// frame-level reference (bit lists per frame, queue model of the RX FIFO).
module tb_uart_core_p;

  localparam int unsigned CLK_DIV = 434;
  localparam int unsigned DB      = 8;
  localparam int unsigned SB      = 1;
  localparam int unsigned DEPTH   = 4;
  localparam bit          PODD    = 1'b0;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr = 1'b0;
  logic [DB-1:0] dat_in = '0;
  logic          busy, tx;
  logic          rx = 1'b1;
  logic          rd = 1'b0;
  logic [DB-1:0] dat_out;
  logic          rx_busy, empty, full, ovf, frm, par;

  int checks = 0;
  int errors = 0;
  int frm_cnt = 0;
  int par_cnt = 0;

  logic          fbits[$];
  logic [DB-1:0] q_model[$];
  bit            ovf_model = 1'b0;

  uart_core_p #(
    .CLK_DIV       (CLK_DIV),
    .DATA_BITS     (DB),
    .STOP_BITS     (SB),
    .RX_FIFO_DEPTH (DEPTH),
    .PARITY_ODD    (0)
  ) dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (rst),
    .uart_wr_i     (wr),
    .uart_dat_i    (dat_in),
    .uart_busy     (busy),
    .uart_tx       (tx),
    .uart_rx       (rx),
    .uart_rd_i     (rd),
    .uart_dat_o    (dat_out),
    .uart_rx_busy  (rx_busy),
    .uart_rx_empty (empty),
    .uart_rx_full  (full),
    .uart_rx_ovf   (ovf),
    .uart_frm_err  (frm),
    .uart_par_err  (par)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (frm) frm_cnt <= frm_cnt + 1;
    if (par) par_cnt <= par_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line levels, one per bit period.
  task automatic make_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_flip);
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < DB; i++) fbits.push_back(d[i]);
    if (PAR_EN) fbits.push_back((^d) ^ PODD ^ par_flip);
    fbits.push_back(stop_v);
    for (int i = 1; i < SB; i++) fbits.push_back(1'b1);
  endtask

  task automatic tx_frame(input logic [DB-1:0] d, input int ign_at, input string tag);
    int n;
    make_frame(d, 1'b1, 1'b0);
    n = fbits.size() * CLK_DIV;
    wr = 1'b1;
    dat_in = d;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      wr = (k == ign_at);
      dat_in = (k == ign_at) ? ~d : d;
      if ((k % CLK_DIV == 0) || (k % CLK_DIV == CLK_DIV / 2) || (k % CLK_DIV == CLK_DIV - 1)) begin
        chk({tag, "_tx"}, 32'(tx), 32'(fbits[k / CLK_DIV]));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
      end
      @(negedge clk);
    end
    wr = 1'b0;
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  task automatic chk_fifo(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'(q_model.size() == 0));
    chk({tag, "_full"}, 32'(full), 32'(q_model.size() == DEPTH));
    chk({tag, "_ovf"}, 32'(ovf), 32'(ovf_model));
    if (q_model.size() != 0) chk({tag, "_dat"}, 32'(dat_out), 32'(q_model[0]));
    else chk({tag, "_dat"}, 32'(dat_out), 32'd0);
  endtask

  task automatic rx_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_flip,
                          input string tag);
    int nb, frm0, par0;
    bit good;
    make_frame(d, stop_v, par_flip);
    nb = fbits.size();
    frm0 = frm_cnt;
    par0 = par_cnt;
    for (int b = 0; b < nb; b++) begin
      rx = fbits[b];
      if (b == nb - SB) begin
        @(negedge clk);
        chk({tag, "_busy_stop"}, 32'(rx_busy), 32'd1);
        chk_fifo({tag, "_pre"});
        repeat (CLK_DIV - 1) @(negedge clk);
      end else begin
        repeat (CLK_DIV) @(negedge clk);
      end
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    good = stop_v && !(PAR_EN && par_flip);
    if (good) begin
      if (q_model.size() == DEPTH) ovf_model = 1'b1;
      else q_model.push_back(d);
    end
    chk({tag, "_frm"}, 32'(frm_cnt - frm0), 32'(!stop_v));
    chk({tag, "_par"}, 32'(par_cnt - par0), 32'(stop_v && PAR_EN && par_flip));
    chk({tag, "_busy_end"}, 32'(rx_busy), 32'd0);
    chk_fifo(tag);
  endtask

  task automatic rd_pop(input string tag);
    if (q_model.size() != 0) chk({tag, "_dat"}, 32'(dat_out), 32'(q_model[0]));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (q_model.size() != 0) void'(q_model.pop_front());
    chk_fifo({tag, "_after"});
  endtask

  initial begin
    logic [DB-1:0] r;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_busy", 32'(rx_busy), 32'd0);
    chk("rst_frm", 32'(frm), 32'd0);
    chk("rst_par", 32'(par), 32'd0);
    chk_fifo("rst");

    // TX: plain frame, ignored write mid-frame, back-to-back after busy falls
    tx_frame(8'h1B, -1, "t1");
    tx_frame(8'h1B, 100, "t2a");
    tx_frame(8'h1E, -1, "t2b");

    // RX: single frame then pop
    rx_frame(8'h75, 1'b1, 1'b0, "r75");
    rd_pop("r75_rd");

    // RX: fill, overflow, drain
    for (int i = 1; i <= 5; i++) rx_frame(DB'(i), 1'b1, 1'b0, $sformatf("ovf%0d", i));
    for (int i = 0; i < 4; i++) rd_pop($sformatf("drain%0d", i));
    rd_pop("rd_empty");

    // RX: framing error, then a short low glitch
    rx_frame(8'h55, 1'b0, 1'b0, "frm");
    begin
      int f0;
      f0 = frm_cnt;
      rx = 1'b0;
      repeat (50) @(negedge clk);
      chk("glitch_busy", 32'(rx_busy), 32'd1);
      repeat (50) @(negedge clk);
      rx = 1'b1;
      repeat (CLK_DIV) @(negedge clk);
      chk("glitch_busy_end", 32'(rx_busy), 32'd0);
      chk("glitch_frm", 32'(frm_cnt - f0), 32'd0);
      chk_fifo("glitch");
    end

`ifdef UART_PARITY_EN
    tx_frame(8'h07, -1, "ptx");
    rx_frame(8'h07, 1'b1, 1'b1, "prx");
`endif

    // Random traffic
    for (int i = 0; i < 2; i++) begin
      r = DB'($urandom);
      rx_frame(r, 1'b1, 1'b0, $sformatf("rnd_rx%0d", i));
      if ($urandom_range(1, 0) == 1) rd_pop($sformatf("rnd_rd%0d", i));
    end
    tx_frame(DB'($urandom), -1, "rnd_tx");

    // Reset aborts a TX frame and clears the FIFO and sticky overflow
    wr = 1'b1;
    dat_in = 8'hA5;
    @(negedge clk);
    wr = 1'b0;
    repeat (500) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_ovf_sticky", 32'(ovf), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_model.delete();
    ovf_model = 1'b0;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy_end", 32'(busy), 32'd0);
    chk_fifo("abort");
    repeat (CLK_DIV) @(negedge clk);
    chk("abort_tx_idle", 32'(tx), 32'd1);
    if (!PAR_EN) chk("par_tied", 32'(par_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
